prince_ti_sbox_compress: RTL and testbench
==========================================

# prince_ti_sbox_compress

Register-and-compress stage directly downstream of the PRINCE threshold-implementation S-box layer. It captures the 8 expanded share terms per output bit from all 16 S-box instances in a mandatory TI register stage, then XOR-compresses them back to a 2-share 64-bit state for the linear layer. A 2-entry valid/ready pipeline provides backpressure toward the round controller.

## Interface
- `NLANES`, 16: S-box instances (nibbles) per state; 64-bit state at default.
- `clk_i`  in  1  clock, all state on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous clear of both pipeline stages.
- `in_valid_i`  in  1  expanded shares on `exp_*_i` valid.
- `in_ready_o`  out  1  stage 1 can accept.
- `exp_b0_i`  in  8*NLANES  lane k bits [8k+7:8k] = out1 terms of S-box k (output bit 0).
- `exp_b1_i`, `exp_b2_i`, `exp_b3_i`  in  8*NLANES each  out2/out3/out4 terms (output bits 1..3).
- `rnd_i`  in  4*NLANES  fresh mask (present only with `PRINCE_TI_REFRESH_EN`).
- `out_valid_o`  out  1  compressed shares valid.
- `out_ready_i`  in  1  consumer accepts.
- `sh_a_o`  out  4*NLANES  share A; nibble k bit j = compressed S-box k output bit j.
- `sh_b_o`  out  4*NLANES  share B.

## Operation
- Stage 1 (S1): 32*NLANES-bit register + `v1`. Loads `exp_*_i` unmodified on `in_valid_i && in_ready_o`. No logic between input pins and S1 flops (TI non-completeness boundary).
- Stage 2 (S2): compression from S1 registers, registered into `sh_a/sh_b` + `v2`. Per lane k, output bit j, term vector t[7:0]: A = t0^t1^t2^t3, B = t4^t5^t6^t7. Each XOR tree uses only terms of its own share group; no cross-group mixing before the flop.
- S2 loads when `v1 && (!v2 || out_ready_i)`; S1 loads when `in_ready_o`.
- `in_ready_o = !v1 || (!v2 || out_ready_i)` (combinational from `v1`, `v2`, `out_ready_i`; no path from `in_valid_i`).
- `out_valid_o = v2`; `sh_a_o/sh_b_o` driven directly from S2 flops; held stable while `v2 && !out_ready_i`.
- Simultaneous S1 load and S1→S2 move in one cycle: allowed, full throughput 1 state/cycle.
- `flush_i`: next cycle `v1 = v2 = 0`, all data registers zeroed; a concurrent input handshake is ignored (`in_ready_o` forced 0 while `flush_i` high).
- Data registers not loaded hold value (no toggling of stale shares).

## Timing
- Reset (async assert, `rst_ni` low): `v1 = v2 = 0`, all data flops 0, so `out_valid_o = 0`, `sh_a_o = sh_b_o = 0`, `in_ready_o = 1`.
- Release synchronous to `clk_i` (external synchroniser); first accept on first rising edge with `rst_ni` high.
- Latency: input accepted at edge N → `out_valid_o` high after edge N+1 (2 register stages).
- Stall: with `out_ready_i = 0`, holds 2 states; `in_ready_o` drops after second accept.
- Reset mid-operation: in-flight states discarded, no partial output.

## Configuration
- `PRINCE_TI_REFRESH_EN` defined: `rnd_i` port present; S2 computes A' = A ^ r, B' = B ^ r, r = `rnd_i` bit 4k+j sampled on the S1→S2 transfer edge; unmasked sum A'^B' unchanged.
- Undefined: no `rnd_i` port, A/B registered without refresh.

## Test plan
- Reset: drive `rst_ni = 0` mid-stream with `v1 = v2 = 1` → outputs 0, `out_valid_o = 0`, `in_ready_o = 1` immediately (no clock).
- Compression: lane 0 `exp_b0_i` = 8'b0000_0001, all else 0 → 2 cycles later `sh_a_o = 64'h1`, `sh_b_o = 0`; repeat with 8'b0001_0000 → `sh_a_o = 0`, `sh_b_o = 64'h1`.
- Full PRINCE S-box: random 2-share states through reference s-box model, 1000 vectors → `sh_a_o ^ sh_b_o` equals PRINCE S(x) per nibble; one output per cycle with `out_ready_i = 1`.
- Backpressure: `out_ready_i = 0` for 5 cycles with 3 offered states → 2 accepted, `in_ready_o = 0` from third cycle, outputs stable; release → states emitted in order, none lost or duplicated.
- Flush: `flush_i` with both stages full and `in_valid_i = 1` → next cycle `out_valid_o = 0`, data 0, input not captured.
- Refresh (`PRINCE_TI_REFRESH_EN`): `rnd_i` = all ones, lane input as scenario 2 → `sh_a_o = ~64'h1`, `sh_b_o = ~64'h0`, XOR still 64'h1.

Source files
------------

// File: rtl/prince_ti_sbox_compress.sv
// prince_ti_sbox_compress
//   Register-and-compress stage behind the PRINCE threshold-implementation
//   S-box layer. Stage 1 captures the 8 expanded share terms per output bit
//   of every S-box lane with no logic in front of the flops. Stage 2 XOR-folds
//   terms 0..3 into share A and terms 4..7 into share B and registers them.
//   The two stages form a 2-entry valid/ready pipeline.
//
//   Optional feature macro: PRINCE_TI_REFRESH_EN
//     When defined, rnd_i is present and both compressed shares are XORed with
//     the same fresh mask bit on the stage-1 to stage-2 transfer edge.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   flush_i      synchronous clear of both stages
//   in_valid_i   expanded shares valid
//   in_ready_o   stage 1 can accept
//   exp_b0_i..exp_b3_i  lane k byte [8k+7:8k] = 8 terms of S-box k output bit 0..3
//   rnd_i        fresh mask, bit 4k+j for lane k bit j (refresh build only)
//   out_valid_o  compressed shares valid
//   out_ready_i  consumer accepts
//   sh_a_o       share A, nibble k bit j = compressed S-box k bit j
//   sh_b_o       share B
module prince_ti_sbox_compress #(
  parameter int unsigned NLANES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [8*NLANES-1:0]   exp_b0_i,
  input  logic [8*NLANES-1:0]   exp_b1_i,
  input  logic [8*NLANES-1:0]   exp_b2_i,
  input  logic [8*NLANES-1:0]   exp_b3_i,
`ifdef PRINCE_TI_REFRESH_EN
  input  logic [4*NLANES-1:0]   rnd_i,
`endif
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4*NLANES-1:0]   sh_a_o,
  output logic [4*NLANES-1:0]   sh_b_o
);

  logic [8*NLANES-1:0] s1_b0, s1_b1, s1_b2, s1_b3;
  logic                v1;
  logic [4*NLANES-1:0] sh_a, sh_b;
  logic                v2;

  logic [4*NLANES-1:0] comp_a, comp_b;
  logic                s1_load, s2_load;

  // Readiness depends only on occupancy and the consumer, never on in_valid_i.
  assign in_ready_o = !flush_i && (!v1 || !v2 || out_ready_i);
  assign s1_load    = in_valid_i && in_ready_o;
  assign s2_load    = v1 && (!v2 || out_ready_i);

  // Each share's XOR tree reads only its own group of four terms so the
  // A and B domains never meet before the stage-2 flops.
  always_comb begin
    comp_a = '0;
    comp_b = '0;
    for (int unsigned k = 0; k < NLANES; k++) begin
      comp_a[4*k+0] = ^s1_b0[8*k +: 4];
      comp_b[4*k+0] = ^s1_b0[8*k+4 +: 4];
      comp_a[4*k+1] = ^s1_b1[8*k +: 4];
      comp_b[4*k+1] = ^s1_b1[8*k+4 +: 4];
      comp_a[4*k+2] = ^s1_b2[8*k +: 4];
      comp_b[4*k+2] = ^s1_b2[8*k+4 +: 4];
      comp_a[4*k+3] = ^s1_b3[8*k +: 4];
      comp_b[4*k+3] = ^s1_b3[8*k+4 +: 4];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_b0 <= '0;
      s1_b1 <= '0;
      s1_b2 <= '0;
      s1_b3 <= '0;
      v1    <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      v2    <= 1'b0;
    end else if (flush_i) begin
      s1_b0 <= '0;
      s1_b1 <= '0;
      s1_b2 <= '0;
      s1_b3 <= '0;
      v1    <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      v2    <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_b0 <= exp_b0_i;
        s1_b1 <= exp_b1_i;
        s1_b2 <= exp_b2_i;
        s1_b3 <= exp_b3_i;
      end
      if (s2_load) begin
`ifdef PRINCE_TI_REFRESH_EN
        sh_a <= comp_a ^ rnd_i;
        sh_b <= comp_b ^ rnd_i;
`else
        sh_a <= comp_a;
        sh_b <= comp_b;
`endif
      end
      // Stage 1 may refill in the same cycle it hands its entry to stage 2.
      if (s1_load)      v1 <= 1'b1;
      else if (s2_load) v1 <= 1'b0;
      if (s2_load)          v2 <= 1'b1;
      else if (out_ready_i) v2 <= 1'b0;
    end
  end

  assign out_valid_o = v2;
  assign sh_a_o      = sh_a;
  assign sh_b_o      = sh_b;

endmodule

// File: tb/tb_prince_ti_sbox_compress.sv
// Testbench for prince_ti_sbox_compress (NLANES = 16): directed vector table,
// random 2-share PRINCE S-box states, backpressure, flush and reset sequences.
module tb_prince_ti_sbox_compress;

  typedef struct {
    logic [127:0] b0, b1, b2, b3;
    logic [63:0]  a, b;
    logic [63:0]  x;
    bit           chk_s;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] e0, e1, e2, e3;
  logic [63:0]  sh_a, sh_b;
`ifdef PRINCE_TI_REFRESH_EN
  logic [63:0]  rnd;
`endif

  int checks = 0;
  int failures = 0;
  int stalls = 0;
  vec_t stim_q[$];
  vec_t exp_q[$];
  vec_t tbl[8];

  prince_ti_sbox_compress #(.NLANES(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .exp_b0_i(e0), .exp_b1_i(e1), .exp_b2_i(e2), .exp_b3_i(e3),
`ifdef PRINCE_TI_REFRESH_EN
    .rnd_i(rnd),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sh_a_o(sh_a), .sh_b_o(sh_b)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hB; 4'h1: sbox = 4'hF; 4'h2: sbox = 4'h3; 4'h3: sbox = 4'h2;
      4'h4: sbox = 4'hA; 4'h5: sbox = 4'hC; 4'h6: sbox = 4'h9; 4'h7: sbox = 4'h1;
      4'h8: sbox = 4'h6; 4'h9: sbox = 4'h7; 4'hA: sbox = 4'h8; 4'hB: sbox = 4'h0;
      4'hC: sbox = 4'hE; 4'hD: sbox = 4'h5; 4'hE: sbox = 4'hD; default: sbox = 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] sbox_state(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int k = 0; k < 16; k++) y[4*k +: 4] = sbox(x[4*k +: 4]);
    return y;
  endfunction

  function automatic vec_t mk(input logic [127:0] b0, b1, b2, b3,
                              input logic [63:0] a, b);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.a = a; v.b = b; v.x = '0; v.chk_s = 1'b0;
    return v;
  endfunction

  // Random state x split into 8 terms per output bit whose XOR is S(x) bit j.
  function automatic vec_t gen_rand();
    vec_t v;
    logic [127:0] bb [4];
    logic [7:0]   t;
    logic [3:0]   s;
    v.x = {$urandom, $urandom};
    v.a = '0; v.b = '0; v.chk_s = 1'b1;
    for (int j = 0; j < 4; j++) bb[j] = '0;
    for (int k = 0; k < 16; k++) begin
      s = sbox(v.x[4*k +: 4]);
      for (int j = 0; j < 4; j++) begin
        t = 8'($urandom);
        t[7] = (^t[6:0]) ^ s[j];
        bb[j][8*k +: 8] = t;
        v.a[4*k+j] = ^t[3:0];
        v.b[4*k+j] = ^t[7:4];
      end
    end
    v.b0 = bb[0]; v.b1 = bb[1]; v.b2 = bb[2]; v.b3 = bb[3];
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    e0 = v.b0; e1 = v.b1; e2 = v.b2; e3 = v.b3;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    e0 = '0; e1 = '0; e2 = '0; e3 = '0;
  endtask

  task automatic compare_out(input vec_t v);
    check64("sh_a", sh_a, v.a);
    check64("sh_b", sh_b, v.b);
    if (v.chk_s) check64("sbox_sum", sh_a ^ sh_b, sbox_state(v.x));
  endtask

  // Streams stim_q with out_ready high; outputs compared in order against exp_q.
  task automatic run_stream(input int budget);
    int cyc = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      out_ready = 1'b1;
      flush = 1'b0;
      if (stim_q.size() != 0) begin
        drive(stim_q[0]);
        in_valid = 1'b1;
      end else begin
        idle_inputs();
      end
      #1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output actual=%h/%h required=none", sh_a, sh_b);
        end else begin
          compare_out(exp_q.pop_front());
        end
      end
      if (in_valid) begin
        if (in_ready) exp_q.push_back(stim_q.pop_front());
        else stalls++;
      end
      cyc++;
    end
    if (stim_q.size() != 0 || exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL stream_timeout actual=%0d pending required=0", stim_q.size() + exp_q.size());
      stim_q.delete();
      exp_q.delete();
    end
  endtask

  // Offers a then b with the consumer stalled so both stages end up full.
  task automatic fill_two(input vec_t a, input vec_t b);
    @(negedge clk);
    out_ready = 1'b0; drive(a); in_valid = 1'b1;
    @(negedge clk);
    drive(b);
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    idle_inputs();
`ifdef PRINCE_TI_REFRESH_EN
    rnd = '0;
`endif
    tbl[0] = mk(128'h01, '0, '0, '0, 64'h1, 64'h0);
    tbl[1] = mk(128'h10, '0, '0, '0, 64'h0, 64'h1);
    tbl[2] = mk('0, 128'h03, '0, '0, 64'h0, 64'h0);
    tbl[3] = mk('0, '0, 128'h07, '0, 64'h4, 64'h0);
    tbl[4] = mk('0, '0, '0, {8'h80, 120'h0}, 64'h0, 64'h8000_0000_0000_0000);
    tbl[5] = mk('1, '1, '1, '1, 64'h0, 64'h0);
    tbl[6] = mk({16{8'h01}}, '0, '0, '0, 64'h1111_1111_1111_1111, 64'h0);
    tbl[7] = mk('0, 128'h2100_0000, '0, '0, 64'h2000, 64'h2000);

    #3;
    check1("reset_out_valid", out_valid, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    check64("reset_sh_a", sh_a, '0);
    check64("reset_sh_b", sh_b, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back to back.
    for (int i = 0; i < 8; i++) stim_q.push_back(tbl[i]);
    stalls = 0;
    run_stream(40);
    check1("table_no_stall", stalls == 0, 1'b1);

    // Backpressure: 3 states offered over 5 stalled cycles, 2 accepted.
    @(negedge clk);
    out_ready = 1'b0; drive(tbl[0]); in_valid = 1'b1;
    #1 check1("bp_ready_c1", in_ready, 1'b1);
    @(negedge clk);
    drive(tbl[1]);
    #1 check1("bp_ready_c2", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(tbl[6]); in_valid = 1'b1;
      #1;
      check1("bp_in_ready", in_ready, 1'b0);
      check1("bp_out_valid", out_valid, 1'b1);
      check64("bp_hold_a", sh_a, tbl[0].a);
      check64("bp_hold_b", sh_b, tbl[0].b);
    end
    exp_q.push_back(tbl[0]);
    exp_q.push_back(tbl[1]);
    stim_q.push_back(tbl[6]);
    run_stream(20);

    // Flush with both stages full and an input offered.
    fill_two(tbl[0], tbl[1]);
    @(negedge clk);
    flush = 1'b1; drive(tbl[6]); in_valid = 1'b1; out_ready = 1'b0;
    #1 check1("flush_in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0; idle_inputs();
    #1;
    check1("flush_out_valid", out_valid, 1'b0);
    check64("flush_sh_a", sh_a, '0);
    check64("flush_sh_b", sh_b, '0);
    check1("flush_in_ready_after", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check1("flush_not_captured", out_valid, 1'b0);

    // Asynchronous reset mid-stream, checked before any clock edge.
    fill_two(tbl[0], tbl[6]);
    #1 check1("pre_reset_full", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("areset_out_valid", out_valid, 1'b0);
    check1("areset_in_ready", in_ready, 1'b1);
    check64("areset_sh_a", sh_a, '0);
    check64("areset_sh_b", sh_b, '0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check1("areset_no_residue", out_valid, 1'b0);

`ifdef PRINCE_TI_REFRESH_EN
    rnd = '1;
    begin
      vec_t r;
      r = mk(128'h01, '0, '0, '0, ~64'h1, ~64'h0);
      stim_q.push_back(r);
      run_stream(10);
      check64("refresh_sum", sh_a ^ sh_b, 64'h1);
    end
    rnd = '0;
`endif

    // Random 2-share PRINCE S-box states at full throughput.
    for (int n = 0; n < 1000; n++) stim_q.push_back(gen_rand());
    stalls = 0;
    run_stream(1100);
    check1("random_no_stall", stalls == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
